// File: rtl/sine_lut_arbiter.sv
// Round-robin arbiter sharing one 16-entry sine lookup between requesters.
// Optional macro SINE_ARB_PRIO0_EN gives requester 0 strict priority.

module sine_lut (
  input  logic [3:0] pos,
  output logic [7:0] sin_output
);

  // 16-point sine, offset 128, amplitude 127, rounded to nearest
  always_comb begin
    sin_output = 8'd128;
    unique case (pos)
      4'd0:  sin_output = 8'd128;
      4'd1:  sin_output = 8'd177;
      4'd2:  sin_output = 8'd218;
      4'd3:  sin_output = 8'd245;
      4'd4:  sin_output = 8'd255;
      4'd5:  sin_output = 8'd245;
      4'd6:  sin_output = 8'd218;
      4'd7:  sin_output = 8'd177;
      4'd8:  sin_output = 8'd128;
      4'd9:  sin_output = 8'd79;
      4'd10: sin_output = 8'd38;
      4'd11: sin_output = 8'd11;
      4'd12: sin_output = 8'd1;
      4'd13: sin_output = 8'd11;
      4'd14: sin_output = 8'd38;
      4'd15: sin_output = 8'd79;
      default: sin_output = 8'd128;
    endcase
  end

endmodule

module sine_lut_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] pos_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam logic [2:0] NR   = 3'(NUM_REQ);
  localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

  logic [1:0] rr_ptr;
  logic [1:0] rr_nxt;
  logic [1:0] win;
  logic [2:0] idx;
  logic       hit;
  logic [3:0] pos_sel;
  logic [7:0] sin_out;

  // Winner search starting at rr_ptr; grant suppressed during reset
  always_comb begin
    hit = 1'b0;
    win = 2'd0;
    idx = 3'd0;
    gnt = '0;
`ifdef SINE_ARB_PRIO0_EN
    if (req[0]) begin
      hit = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx = {1'b0, rr_ptr} + 3'(k);
        if (idx > {1'b0, LAST}) idx = idx - (NR - 3'd1);
        if (!hit && req[idx]) begin
          hit = 1'b1;
          win = idx[1:0];
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 3'(k);
      if (idx >= NR) idx = idx - NR;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx[1:0];
      end
    end
`endif
    if (rst) hit = 1'b0;
    if (hit) gnt[win] = 1'b1;
  end

  // Pointer moves to the slot just past the winner
  always_comb begin
    rr_nxt = rr_ptr;
    if (hit) begin
`ifdef SINE_ARB_PRIO0_EN
      if (win != 2'd0)
        rr_nxt = (win == LAST) ? 2'd1 : win + 2'd1;
`else
      rr_nxt = (win == LAST) ? 2'd0 : win + 2'd1;
`endif
    end
  end

  // Winner's position drives the shared lookup
  always_comb begin
    pos_sel = pos_in[4*win +: 4];
  end

  sine_lut u_lut (
    .pos        (pos_sel),
    .sin_output (sin_out)
  );

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef SINE_ARB_PRIO0_EN
      rr_ptr <= 2'd1;
`else
      rr_ptr <= 2'd0;
`endif
    end else begin
      rr_ptr <= rr_nxt;
    end
  end

  // Registered response; data holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= 8'd0;
    end else if (hit) begin
      rsp_valid <= gnt;
      rsp_data  <= sin_out;
    end else begin
      rsp_valid <= '0;
    end
  end

  // Saturating count of cycles with two or more requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if ($countones(req) >= 2 && conflict_cnt != {CNT_W{1'b1}}) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Self-checking bench for sine_lut_arbiter with a behavioural model.
// Honours SINE_ARB_PRIO0_EN in the model when the macro is defined.

module tb_sine_lut_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [11:0] pos_in = '0;
  logic [2:0]  gnt, gnt2;
  logic [2:0]  rsp_valid, rsp_valid2;
  logic [7:0]  rsp_data, rsp_data2;
  logic [7:0]  conflict_cnt;
  logic [1:0]  conflict_cnt2;

  int checks = 0;
  int failures = 0;

  int         m_rr;
  logic [2:0] m_valid;
  logic [7:0] m_data;
  int         m_cnt;
  int         m_cnt2;

  always #5 clk = ~clk;

  sine_lut_arbiter #(.NUM_REQ(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .pos_in(pos_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .conflict_cnt(conflict_cnt)
  );

  sine_lut_arbiter #(.NUM_REQ(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .pos_in(pos_in),
    .gnt(gnt2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .conflict_cnt(conflict_cnt2)
  );

  function automatic logic [7:0] golden(input int p);
    real x;
    x = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * p / 16.0);
    return 8'($rtoi(x + 0.5));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [2:0] r);
    int c;
`ifdef SINE_ARB_PRIO0_EN
    if (r[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      c = 1 + ((m_rr - 1 + k) % (N - 1));
      if (r[c]) return c;
    end
`else
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
`ifdef SINE_ARB_PRIO0_EN
    m_rr = 1;
`else
    m_rr = 0;
`endif
    m_valid = '0;
    m_data  = '0;
    m_cnt   = 0;
    m_cnt2  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b111;
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_data", int'(rsp_data), 0);
    chk("rst_cnt", int'(conflict_cnt), 0);
    chk("rst_cnt2", int'(conflict_cnt2), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;
    model_reset();
  endtask

  task automatic step(input logic [2:0] r, input logic [11:0] p);
    int w;
    int pc;
    req = r;
    pos_in = p;
    w = winner(r);
    @(negedge clk);
    chk("gnt", int'(gnt), (w < 0) ? 0 : (1 << w));
    chk("rsp_valid", int'(rsp_valid), int'(m_valid));
    chk("rsp_data", int'(rsp_data), int'(m_data));
    chk("cnt", int'(conflict_cnt), m_cnt);
    chk("cnt2", int'(conflict_cnt2), m_cnt2);
    @(posedge clk);
    #1;
    pc = $countones(r);
    if (pc >= 2) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (w < 0) begin
      m_valid = '0;
    end else begin
      m_valid = 3'(1 << w);
      m_data = golden(int'((p >> (4 * w)) & 12'hF));
`ifdef SINE_ARB_PRIO0_EN
      if (w != 0) m_rr = (w == N - 1) ? 1 : w + 1;
`else
      m_rr = (w + 1) % N;
`endif
    end
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    step(3'b010, 12'h040);
    step(3'b000, 12'h000);
    step(3'b000, 12'h000);

    do_reset();
    for (int i = 0; i < 6; i++) step(3'b111, 12'($urandom));
    step(3'b000, 12'h000);
    chk("rot_cnt", int'(conflict_cnt), 6);

    step(3'b100, 12'hF00);
    step(3'b000, 12'h000);
    chk("pos15_data", int'(rsp_data), int'(golden(15)));
    step(3'b101, 12'h357);

    step(3'b010, 12'h0A0);
    do_reset();
    step(3'b110, 12'h9C0);

    do_reset();
    for (int i = 0; i < 10; i++) step(3'b011, 12'($urandom));
    chk("sat_cnt2", int'(conflict_cnt2), 3);
    chk("sat_cnt", int'(conflict_cnt), 10);

    for (int i = 0; i < 120; i++) step(3'($urandom), 12'($urandom));

    for (int i = 0; i < 300; i++) step(3'b111, 12'($urandom));
    step(3'b000, 12'h000);
    chk("cnt_sat8", int'(conflict_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
